// File: rtl/uart_fifo_tx.sv
// UART transmitter that pulls bytes from a first-word fall-through FIFO.
// Frames are 1 start bit, DBIT data bits LSB first, and a configurable stop length.
module uart_fifo_tx #(
  parameter int DBIT      = 8,
  parameter int SB_TICK   = 16,
  parameter int DVSR      = 81,
  parameter int DVSR_BITS = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tx_en,
  input  logic            fifo_empty,
  input  logic [DBIT-1:0] fifo_r_data,
  output logic            fifo_rd,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick
);

  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam int SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t               state, state_n;
  logic [SW-1:0]        s, s_n;
  logic [NW-1:0]        n, n_n;
  logic [DBIT-1:0]      b, b_n;
  logic [DVSR_BITS-1:0] dcnt;
  logic                 tx_reg, tx_n;
  logic                 s_tick;
  logic                 pop;
  logic                 done;

  assign s_tick = (dcnt == DVSR_BITS'(DVSR - 1));

  // Tick divider; restarted on a pop so the start bit is phase-aligned.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dcnt <= '0;
    end else if (pop || s_tick) begin
      dcnt <= '0;
    end else begin
      dcnt <= dcnt + DVSR_BITS'(1);
    end
  end

  // Frame state, counters, shift register and registered line output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      s      <= '0;
      n      <= '0;
      b      <= '0;
      tx_reg <= 1'b1;
    end else begin
      state  <= state_n;
      s      <= s_n;
      n      <= n_n;
      b      <= b_n;
      tx_reg <= tx_n;
    end
  end

  // Next-state logic, pop strobe and done pulse.
  always_comb begin
    state_n = state;
    s_n     = s;
    n_n     = n;
    b_n     = b;
    pop     = 1'b0;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (tx_en && !fifo_empty && !reset) begin
          pop     = 1'b1;
          b_n     = fifo_r_data;
          s_n     = '0;
          state_n = START;
        end
      end
      START: begin
        if (s_tick) begin
          if (s == SW'(15)) begin
            s_n     = '0;
            n_n     = '0;
            state_n = DATA;
          end else begin
            s_n = s + SW'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s == SW'(15)) begin
            s_n = '0;
            b_n = b >> 1;
            if (n == NW'(DBIT - 1)) begin
              state_n = STOP;
            end else begin
              n_n = n + NW'(1);
            end
          end else begin
            s_n = s + SW'(1);
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s == SW'(SB_TICK - 1)) begin
            done    = 1'b1;
            state_n = IDLE;
          end else begin
            s_n = s + SW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Line level for the upcoming state, so tx switches with the state register.
  always_comb begin
    tx_n = 1'b1;
    unique case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = b_n[0];
      default: tx_n = 1'b1;
    endcase
  end

  assign fifo_rd      = pop;
  assign tx           = tx_reg;
  assign tx_busy      = (state != IDLE);
  assign tx_done_tick = done;

endmodule
